// File: rtl/tdm_demux16.sv
// 1:16 time-division demultiplexer: a serial stream is steered slot-by-slot into a shadow
// register, which is copied to q at frame end. Define DEMUX_PARITY_EN to add a 17th parity slot.
module tdm_demux16 #(
   parameter int unsigned IDLE_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic [3:0]  sel,
   input  logic        din,
   input  logic        din_valid,
   input  logic        frame_start,
   output logic [15:0] q,
   output logic [3:0]  cur_slot,
   output logic        busy,
   output logic        frame_done,
`ifdef DEMUX_PARITY_EN
   output logic        parity_err,
`endif
   output logic        frame_abort
);

   // state  | meaning
   // S_IDLE | waiting for frame_start (or in manual mode)
   // S_RECV | collecting slots into the shadow register
   typedef enum logic {S_IDLE, S_RECV} state_t;

`ifdef DEMUX_PARITY_EN
   localparam int unsigned SW = 5;
   localparam logic [SW-1:0] LAST_SLOT = 5'd16;
`else
   localparam int unsigned SW = 4;
   localparam logic [SW-1:0] LAST_SLOT = 4'd15;
`endif
   localparam logic [7:0] TO_LAST = 8'(IDLE_TIMEOUT - 1);

   state_t          state_q;
   logic [SW-1:0]   slot_q;
   logic [15:0]     shadow_q;
   logic [15:0]     q_q;
   logic [7:0]      tcnt_q;
   logic            done_q;
   logic            abort_q;
   logic            perr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         slot_q   <= '0;
         shadow_q <= '0;
         q_q      <= '0;
         tcnt_q   <= '0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         perr_q  <= 1'b0;
         if (mode) begin
            // manual write drops any partial frame without signalling
            state_q <= S_IDLE;
            slot_q  <= '0;
            tcnt_q  <= '0;
            if (din_valid) q_q[sel] <= din;
         end else begin
            case (state_q)
               S_IDLE: begin
                  tcnt_q <= '0;
                  if (frame_start) begin
                     state_q <= S_RECV;
                     if (din_valid) begin
                        shadow_q[0] <= din;
                        slot_q      <= SW'(1);
                     end else begin
                        slot_q <= '0;
                     end
                  end
               end
               S_RECV: begin
                  if (din_valid && slot_q == LAST_SLOT) begin
`ifdef DEMUX_PARITY_EN
                     if (din == ^shadow_q) begin
                        q_q    <= shadow_q;
                        done_q <= 1'b1;
                     end else begin
                        perr_q <= 1'b1;
                     end
`else
                     q_q    <= {din, shadow_q[14:0]};
                     done_q <= 1'b1;
`endif
                     // a coincident frame_start opens a fresh frame at slot 0
                     slot_q  <= '0;
                     tcnt_q  <= '0;
                     state_q <= frame_start ? S_RECV : S_IDLE;
                  end else if (frame_start) begin
                     abort_q <= 1'b1;
                     tcnt_q  <= '0;
                     if (din_valid) begin
                        shadow_q[0] <= din;
                        slot_q      <= SW'(1);
                     end else begin
                        slot_q <= '0;
                     end
                  end else if (din_valid) begin
                     shadow_q[slot_q[3:0]] <= din;
                     slot_q                <= slot_q + 1'b1;
                     tcnt_q                <= '0;
                  end else if (IDLE_TIMEOUT != 0) begin
                     if (tcnt_q == TO_LAST) begin
                        abort_q <= 1'b1;
                        state_q <= S_IDLE;
                        slot_q  <= '0;
                        tcnt_q  <= '0;
                     end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign q           = q_q;
   assign cur_slot    = slot_q[3:0];
   assign busy        = (state_q == S_RECV);
   assign frame_done  = done_q;
   assign frame_abort = abort_q;
`ifdef DEMUX_PARITY_EN
   assign parity_err  = perr_q;
`else
   logic unused_perr;
   assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 (IDLE_TIMEOUT=4); covers parity slot when
// DEMUX_PARITY_EN is defined.
module tb_tdm_demux16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [3:0]  sel;
   logic        din;
   logic        din_valid;
   logic        frame_start;
   logic [15:0] q;
   logic [3:0]  cur_slot;
   logic        busy;
   logic        frame_done;
   logic        frame_abort;
`ifdef DEMUX_PARITY_EN
   logic        parity_err;
`endif

   int checks = 0;
   int errors = 0;

   tdm_demux16 #(.IDLE_TIMEOUT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .sel         (sel),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .q           (q),
      .cur_slot    (cur_slot),
      .busy        (busy),
      .frame_done  (frame_done),
`ifdef DEMUX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .frame_abort (frame_abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // drive one cycle of inputs, then sample 1 ns after the edge
   task automatic cyc(input logic fs, input logic v, input logic d);
      frame_start = fs;
      din_valid   = v;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   // parity slot closes the frame when the feature is built in
   task automatic close_frame(input logic [15:0] w, input logic fs);
`ifdef DEMUX_PARITY_EN
      cyc(fs, 1'b1, ^w);
`else
      chk("close_frame_unused", {16'h0, w}, {16'h0, w});
`endif
   endtask

   logic [15:0] w;

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = 4'd0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("rst_q", {16'h0, q}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_slot", {28'h0, cur_slot}, 32'h0);
      chk("rst_pulses", {30'h0, frame_done, frame_abort}, 32'h0);

      // auto frame A5C3, LSB first
      w = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         cyc(i == 0, 1'b1, w[i]);
`ifndef DEMUX_PARITY_EN
         if (i == 15) break;
`endif
         chk("auto_q_hold", {16'h0, q}, 32'h0);
         chk("auto_no_done", {31'h0, frame_done}, 32'h0);
      end
`ifdef DEMUX_PARITY_EN
      chk("auto_wait_par", {31'h0, busy}, 32'h1);
      cyc(1'b0, 1'b1, ^w);
`endif
      chk("auto_q", {16'h0, q}, 32'h0000A5C3);
      chk("auto_done", {31'h0, frame_done}, 32'h1);
      chk("auto_busy", {31'h0, busy}, 32'h0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("auto_done_1cyc", {31'h0, frame_done}, 32'h0);

      // abort after 7 bits; restart consumes din=1 as slot 0
      w = 16'h1234;
      for (int i = 0; i < 7; i++) cyc(i == 0, 1'b1, w[i]);
      cyc(1'b1, 1'b1, 1'b1);
      chk("abort_pulse", {31'h0, frame_abort}, 32'h1);
      chk("abort_q", {16'h0, q}, 32'h0000A5C3);
      chk("abort_slot", {28'h0, cur_slot}, 32'h1);
      chk("abort_busy", {31'h0, busy}, 32'h1);
      w = 16'h8C71;
      for (int i = 1; i < 16; i++) begin
         cyc(1'b0, 1'b1, w[i]);
         if (i == 1) chk("abort_1cyc", {31'h0, frame_abort}, 32'h0);
      end
      close_frame(w, 1'b0);
      chk("restart_q", {16'h0, q}, 32'h00008C71);
      chk("restart_done", {31'h0, frame_done}, 32'h1);

      // manual writes
      mode = 1'b1; sel = 4'b1001;
      cyc(1'b0, 1'b1, 1'b1);
      chk("man_q9", {16'h0, q}, 32'h00008E71);
      sel = 4'd0;
      cyc(1'b0, 1'b1, 1'b0);
      chk("man_q0", {16'h0, q}, 32'h00008E70);
      sel = 4'd3;
      cyc(1'b1, 1'b0, 1'b1);
      chk("man_novalid", {16'h0, q}, 32'h00008E70);
      chk("man_no_pulse", {29'h0, frame_done, frame_abort, busy}, 32'h0);
      mode = 1'b0;

      // timeout: 3 bits then idle
      for (int i = 0; i < 3; i++) cyc(i == 0, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (i < 4) begin
            chk("to_wait_busy", {31'h0, busy}, 32'h1);
            chk("to_wait_abort", {31'h0, frame_abort}, 32'h0);
         end
      end
      chk("to_abort", {31'h0, frame_abort}, 32'h1);
      chk("to_busy", {31'h0, busy}, 32'h0);
      chk("to_slot", {28'h0, cur_slot}, 32'h0);
      chk("to_q", {16'h0, q}, 32'h00008E70);

      // frame_start on the closing bit: complete, then new frame
      w = 16'h00FF;
      for (int i = 0; i < 15; i++) cyc(i == 0, 1'b1, w[i]);
`ifdef DEMUX_PARITY_EN
      cyc(1'b0, 1'b1, w[15]);
`endif
      frame_start = 1'b1;
`ifdef DEMUX_PARITY_EN
      cyc(1'b1, 1'b1, ^w);
`else
      cyc(1'b1, 1'b1, w[15]);
`endif
      chk("fs15_q", {16'h0, q}, 32'h000000FF);
      chk("fs15_done", {31'h0, frame_done}, 32'h1);
      chk("fs15_abort", {31'h0, frame_abort}, 32'h0);
      chk("fs15_busy", {31'h0, busy}, 32'h1);
      chk("fs15_slot", {28'h0, cur_slot}, 32'h0);
      w = 16'hF00F;
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, w[i]);
      close_frame(w, 1'b0);
      chk("fs15_next_q", {16'h0, q}, 32'h0000F00F);

`ifdef DEMUX_PARITY_EN
      w = 16'h0001;
      for (int i = 0; i < 16; i++) cyc(i == 0, 1'b1, w[i]);
      cyc(1'b0, 1'b1, 1'b1);
      chk("par_ok_q", {16'h0, q}, 32'h00000001);
      chk("par_ok_done", {31'h0, frame_done}, 32'h1);
      chk("par_ok_err", {31'h0, parity_err}, 32'h0);
      for (int i = 0; i < 16; i++) cyc(i == 0, 1'b1, w[i]);
      q_chk_prev: begin
         logic [15:0] prev;
         prev = 16'h0001;
         cyc(1'b0, 1'b1, 1'b0);
         chk("par_bad_err", {31'h0, parity_err}, 32'h1);
         chk("par_bad_done", {31'h0, frame_done}, 32'h0);
         chk("par_bad_q", {16'h0, q}, {16'h0, prev});
      end
      cyc(1'b0, 1'b0, 1'b0);
      chk("par_err_1cyc", {31'h0, parity_err}, 32'h0);
`endif

      // reset mid-frame: no abort pulse
      for (int i = 0; i < 5; i++) cyc(i == 0, 1'b1, 1'b1);
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      chk("rst_mid_q", {16'h0, q}, 32'h0);
      chk("rst_mid_state", {27'h0, frame_abort, busy, cur_slot[2:0]}, 32'h0);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
1:16 time-division demultiplexer, the receive-side counterpart of the 16:1 mux.
- A serial bit stream tagged with valid strobes is steered slot-by-slot into 16 output lines.
- Outputs are held in registers and update atomically at frame end.
- A manual mode writes a single line addressed by explicit select inputs, for lab bring-up.

Parameters:
IDLE_TIMEOUT, 0, cycles without din_valid while receiving before the partial frame is aborted; 0 disables the timeout (range 0-255).

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = auto frame scan, 1 = manual select write
sel  input  4  manual-mode target line (s3..s0 order, sel[3] MSB)
din  input  1  serial data bit
din_valid  input  1  din is valid this cycle
frame_start  input  1  marks slot 0 of a new frame (sampled only when mode=0)
q  output  16  latched demux outputs, q[k] = line dk
cur_slot  output  4  next slot index to be filled
busy  output  1  FSM in RECV
frame_done  output  1  one-cycle pulse: q updated from a complete frame
frame_abort  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (rst_n=0 at edge): q=0, shadow=0, cur_slot=0, FSM=IDLE, busy=0, all pulses 0, timeout counter=0. Reset mid-frame discards the frame with no abort pulse.
- FSM states (mode=0):
  - IDLE: on frame_start=1, go to RECV. If din_valid=1 in the same cycle, that bit is slot 0 and cur_slot becomes 1; otherwise cur_slot stays 0.
  - RECV: each din_valid writes shadow[cur_slot] <= din and increments cur_slot.
- Frame completion: din_valid at cur_slot=15 gives, at that edge:
  - q <= shadow with bit15 = din;
  - cur_slot wraps to 0;
  - FSM returns to IDLE;
  - frame_done=1 for exactly the following cycle.
  - Latency: last bit to q visible is 1 cycle.
- frame_start while in RECV (not at slot 15):
  - q unchanged; frame_abort pulses;
  - restart at slot 0, consuming din if din_valid=1.
- frame_start together with the slot-15 valid bit: the current frame completes (frame_done), then a new frame begins with cur_slot=0 and FSM=RECV; din is not double-counted.
- Timeout (IDLE_TIMEOUT>0):
  - Counter increments each RECV cycle with din_valid=0 and clears on any valid.
  - Reaching IDLE_TIMEOUT: frame_abort pulses, FSM=IDLE, cur_slot=0, q unchanged.
- Manual mode (mode=1):
  - FSM forced to IDLE, cur_slot=0, shadow untouched.
  - din_valid=1 gives q[sel] <= din at the next edge; all other q bits hold.
  - No frame_done or frame_abort pulses.
  - Switching mode 0→1 mid-frame discards the partial frame silently.
- busy = (FSM==RECV). q never shows a partial frame in mode 0.

Optional Feature:
Macro DEMUX_PARITY_EN.
- Defined:
  - Adds output port parity_err (1 bit).
  - Each auto frame carries a 17th valid bit (slot 16) holding even parity over the 16 data bits; cur_slot widens internally to 5 bits, while the external cur_slot port shows the low 4 bits.
  - After the slot-15 bit the FSM stays in RECV awaiting the parity bit.
  - On the parity bit: if it matches, q updates and frame_done pulses; on mismatch, q holds and parity_err pulses one cycle (no frame_done).
  - Manual mode is unaffected.
- Undefined: 16-slot frames, no parity_err port.

Test Plan:
- Reset then idle: q=16'h0000, busy=0, cur_slot=0, no pulses.
- Auto frame: frame_start+valid with bits LSB-first encoding 16'hA5C3, one valid per cycle → q stays 0 until the cycle after bit 15, then q=16'hA5C3, frame_done high exactly 1 cycle, busy=0.
- Abort: 7 valid bits of a frame, then frame_start with din=1 → frame_abort 1 cycle, q unchanged (16'hA5C3), cur_slot=1; the next 15 bits complete a new frame normally.
- Manual mode: mode=1, sel=4'b1001, din=1, valid → q[9]=1, other bits hold; sel=0, din=0 → q[0]=0.
- Timeout (IDLE_TIMEOUT=4): 3 bits, then 4 idle cycles → frame_abort on the 4th idle cycle, busy=0, cur_slot=0, q unchanged.
- DEMUX_PARITY_EN: frame 16'h0001 with parity bit 1 → q=16'h0001, frame_done. Same frame with parity bit 0 → parity_err 1 cycle, q holds its previous value.
